// File: rtl/mul_pkg.sv
// Shared constants and the product-stage record for the pipelined multiplier.
package mul_pkg;

  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 8;

  localparam int unsigned DEF_BITLEN = 17;
  localparam int unsigned DEF_TAG_W  = 4;

  // Product width carried by every product stage.
  function automatic int unsigned prod_w(input int unsigned bitlen);
    return 2 * bitlen;
  endfunction

  // Product-stage record at the default widths; mul_pipe re-declares the same
  // layout at its own parameter widths.
  typedef struct packed {
    logic                         valid;
    logic [DEF_TAG_W-1:0]         tag;
    logic [2*DEF_BITLEN-1:0]      prod;
  } stage_rec_t;

endpackage

// File: rtl/mul_trees.sv
// Radix-4 Booth multiplier core: signed N x N operands, product truncated to OUT_W bits.
module mul_trees #(
  parameter int unsigned N     = 18,
  parameter int unsigned OUT_W = 2 * N
) (
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  output logic [OUT_W-1:0]    p_o
);

  localparam int unsigned D = (N + 1) / 2;

  logic signed [2*D-1:0] b_sx;
  logic [2*D:0]          bx;
  logic [OUT_W-1:0]      a_sx;
  logic [OUT_W-1:0]      pp;

  // Recode the multiplier into D Booth digits and accumulate modulo 2^OUT_W.
  always_comb begin
    b_sx = (2*D)'(b_i);
    bx   = {b_sx, 1'b0};
    a_sx = OUT_W'(a_i);
    pp   = '0;
    p_o  = '0;
    for (int unsigned j = 0; j < D; j++) begin
      case (bx[2*j +: 3])
        3'b001, 3'b010: pp = a_sx;
        3'b011:         pp = a_sx << 1;
        3'b100:         pp = -(a_sx << 1);
        3'b101, 3'b110: pp = -a_sx;
        default:        pp = '0;
      endcase
      p_o = p_o + (pp << (2*j));
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Valid/ready pipelined multiplier: operand register, Booth core, STAGES product
// registers with per-stage load enables so bubbles collapse under backpressure.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned BITLEN = 17,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITLEN-1:0]     in_a,
  input  logic [BITLEN-1:0]     in_b,
  input  logic                  in_signed,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*BITLEN-1:0]   out_c,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int unsigned PW = prod_w(BITLEN);
  localparam int unsigned EW = BITLEN + 1;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [PW-1:0]     prod;
  } stage_t;

  typedef struct packed {
    logic              valid;
    logic              sgn;
    logic [TAG_W-1:0]  tag;
    logic [BITLEN-1:0] a;
    logic [BITLEN-1:0] b;
  } opnd_t;

  opnd_t                 s0_q, s0_d;
  stage_t                s1_q, s1_d;
  stage_t [STAGES:1]     st_w;
  logic   [STAGES:0]     ld_c;
  logic                  ld_carry;
  logic   [EW-1:0]       a_ext, b_ext;
  logic   [PW-1:0]       core_p;

  // A stage loads when it is empty or everything downstream of it moves.
  always_comb begin
    ld_c     = '0;
    ld_carry = out_ready || !st_w[STAGES].valid;
    ld_c[STAGES] = ld_carry;
    for (int k = int'(STAGES) - 1; k >= 1; k--) begin
      ld_carry = ld_carry || !st_w[k].valid;
      ld_c[k]  = ld_carry;
    end
    ld_c[0] = ld_carry || !s0_q.valid;
  end

  assign in_ready = ld_c[0] && !reset;

  always_comb begin
    s0_d = s0_q;
    if (ld_c[0]) begin
      s0_d.valid = in_valid;
      s0_d.sgn   = in_signed;
      s0_d.tag   = in_tag;
      s0_d.a     = in_a;
      s0_d.b     = in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) s0_q <= '0;
    else       s0_q <= s0_d;
  end

  assign a_ext = {s0_q.sgn & s0_q.a[BITLEN-1], s0_q.a};
  assign b_ext = {s0_q.sgn & s0_q.b[BITLEN-1], s0_q.b};

  mul_trees #(
    .N     (EW),
    .OUT_W (PW)
  ) u_core (
    .a_i (a_ext),
    .b_i (b_ext),
    .p_o (core_p)
  );

  always_comb begin
    s1_d = s1_q;
    if (ld_c[1]) begin
      s1_d.valid = s0_q.valid;
      s1_d.tag   = s0_q.tag;
      s1_d.prod  = core_p;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  assign st_w[1] = s1_q;

  // Remaining product stages only retime the record.
  for (genvar k = 2; k <= int'(STAGES); k++) begin : g_retime
    stage_t rec_q, rec_d;

    always_comb begin
      rec_d = rec_q;
      if (ld_c[k]) rec_d = st_w[k-1];
    end

    always_ff @(posedge clk) begin
      if (reset) rec_q <= '0;
      else       rec_q <= rec_d;
    end

    assign st_w[k] = rec_q;
  end

  assign out_valid = st_w[STAGES].valid;
  assign out_c     = st_w[STAGES].prod;
  assign out_tag   = st_w[STAGES].tag;

endmodule
